// File: rtl/conv_seq_pkg.sv
// Shared constants, sequencer state type and per-layer history geometry.
package conv_seq_pkg;

  localparam int unsigned ELEM_W   = 16;  // default element width
  localparam int unsigned VEC_D    = 8;   // default elements per vector
  localparam int unsigned NUM_TAPS = 4;   // taps presented to each conv1d layer
  localparam int unsigned DIL_BASE = 4;   // dilation grows by this factor per layer

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_OUTPUT
  } seq_state_t;

  // Dilation of a layer: DIL_BASE ** layer.
  function automatic int unsigned dilation(input int unsigned layer);
    int unsigned d;
    d = 1;
    for (int unsigned i = 0; i < layer; i++) d = d * DIL_BASE;
    return d;
  endfunction

  // History entries needed so the oldest tap (age (NUM_TAPS-1)*d) is still held.
  function automatic int unsigned hist_depth(input int unsigned layer);
    return (NUM_TAPS - 1) * dilation(layer) + 1;
  endfunction

endpackage

// File: rtl/tap_history.sv
// Per-layer ring buffer of past vectors with four dilated, zero-masked taps.
module tap_history
  import conv_seq_pkg::*;
#(
  parameter int          W     = ELEM_W,
  parameter int          D     = VEC_D,
  parameter int unsigned DIL   = 1,
  parameter int unsigned DEPTH = (NUM_TAPS - 1) * DIL + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [D*W-1:0]   wr_data,
  output logic [D*W-1:0]   a0,
  output logic [D*W-1:0]   a1,
  output logic [D*W-1:0]   a2,
  output logic [D*W-1:0]   a3
);

  localparam int DW = D * W;
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [FW-1:0] fill;
  logic [DW-1:0] rd [NUM_TAPS];

  // Pointer and fill count; fill saturates at DEPTH and masks stale entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_en) begin
      wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (fill != FW'(DEPTH)) fill <= fill + FW'(1);
    end
  end

  // Storage write; contents are never cleared, the fill count hides them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  for (genvar m = 0; m < NUM_TAPS; m++) begin : g_tap
    localparam int unsigned AGE  = m * DIL;
    localparam int unsigned BACK = AGE + 1;
    logic [PW-1:0] rd_addr;
    // Newest entry sits one behind wr_ptr; compare in PW+1 bits so BACK==2**PW is safe.
    assign rd_addr = ({1'b0, wr_ptr} >= (PW+1)'(BACK)) ? wr_ptr - PW'(BACK)
                                                        : wr_ptr + PW'(DEPTH - BACK);
    assign rd[m]   = (FW'(AGE) < fill) ? mem[rd_addr] : '0;
  end

  assign a3 = rd[0];
  assign a2 = rd[1];
  assign a1 = rd[2];
  assign a0 = rd[3];

endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs one input vector through NUM_LAYERS external dilated conv1d layers in turn.
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int W          = ELEM_W,
  parameter int D          = VEC_D,
  parameter int NUM_LAYERS = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_v,
  input  logic [D*W-1:0]              in_data,
  output logic                        in_ready,
  output logic [NUM_LAYERS-1:0]       conv_rst,
  output logic                        conv_apply_relu,
  output logic [D*W-1:0]              conv_a0,
  output logic [D*W-1:0]              conv_a1,
  output logic [D*W-1:0]              conv_a2,
  output logic [D*W-1:0]              conv_a3,
  input  logic [NUM_LAYERS-1:0]       conv_out_v,
  input  logic [NUM_LAYERS*D*W-1:0]   conv_out,
  output logic                        out_v,
  output logic [D*W-1:0]              out_data,
  input  logic                        out_ready,
  output logic                        err
);

  localparam int DW = D * W;
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_t      state_q, state_d;
  logic [LW-1:0]   layer_q;
  logic [DW-1:0]   pending_q;
  logic [DW-1:0]   out_data_q;
  logic [TW-1:0]   wait_q;
  logic            err_q;

  logic            last_layer;
  logic            got_result;
  logic            timed_out;
  logic [NUM_LAYERS-1:0] hist_wr;
  logic [DW-1:0]   hist_a0 [NUM_LAYERS];
  logic [DW-1:0]   hist_a1 [NUM_LAYERS];
  logic [DW-1:0]   hist_a2 [NUM_LAYERS];
  logic [DW-1:0]   hist_a3 [NUM_LAYERS];
  logic [DW-1:0]   conv_slice [NUM_LAYERS];

  for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
    assign hist_wr[l]    = (state_q == S_PUSH) && (layer_q == LW'(l));
    assign conv_slice[l] = conv_out[(NUM_LAYERS-1-l)*DW +: DW];

    tap_history #(
      .W    (W),
      .D    (D),
      .DIL  (dilation(l)),
      .DEPTH(hist_depth(l))
    ) u_hist (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (hist_wr[l]),
      .wr_data(pending_q),
      .a0     (hist_a0[l]),
      .a1     (hist_a1[l]),
      .a2     (hist_a2[l]),
      .a3     (hist_a3[l])
    );
  end

  assign last_layer = (layer_q == LW'(NUM_LAYERS - 1));
  assign got_result = conv_out_v[layer_q];
  assign timed_out  = (wait_q == TW'(TIMEOUT - 1));

  // Taps follow the active layer; history is untouched from START to CAPTURE so they hold.
  assign conv_a0         = hist_a0[layer_q];
  assign conv_a1         = hist_a1[layer_q];
  assign conv_a2         = hist_a2[layer_q];
  assign conv_a3         = hist_a3[layer_q];
  assign conv_apply_relu = !last_layer;
  assign out_data        = out_data_q;
  assign err             = err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and control outputs; reset forces every layer into its own reset.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    conv_rst = '0;
    out_v    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_v) state_d = S_PUSH;
      end
      S_PUSH:  state_d = S_START;
      S_START: begin
        conv_rst = NUM_LAYERS'(1) << layer_q;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (got_result)     state_d = S_CAPTURE;
        else if (timed_out) state_d = S_IDLE;
      end
      S_CAPTURE: state_d = last_layer ? S_OUTPUT : S_PUSH;
      S_OUTPUT: begin
        out_v = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      in_ready = 1'b0;
      conv_rst = '1;
    end
  end

  // Datapath: pending vector, layer index, wait counter, result and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_q    <= '0;
      pending_q  <= '0;
      out_data_q <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_v) begin
            pending_q <= in_data;
            layer_q   <= '0;
          end
        end
        S_START: wait_q <= '0;
        S_WAIT: begin
          wait_q <= wait_q + TW'(1);
          if (!got_result && timed_out) err_q <= 1'b1;
        end
        S_CAPTURE: begin
          if (last_layer) begin
            out_data_q <= conv_slice[layer_q];
          end else begin
            pending_q <= conv_slice[layer_q];
            layer_q   <= layer_q + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed + random bench for conv_layer_sequencer with a behavioural conv1d stand-in.
module tb_conv_layer_sequencer;

  localparam int W   = 16;
  localparam int D   = 8;
  localparam int NL  = 3;
  localparam int TO  = 64;
  localparam int DW  = W * D;
  localparam int HMAX = 512;

  logic clk = 1'b0;
  logic rst;
  logic in_v;
  logic [DW-1:0] in_data;
  logic in_ready;
  logic [NL-1:0] conv_rst;
  logic conv_apply_relu;
  logic [DW-1:0] conv_a0, conv_a1, conv_a2, conv_a3;
  logic [NL-1:0] conv_out_v;
  logic [NL*DW-1:0] conv_out;
  logic out_v;
  logic [DW-1:0] out_data;
  logic out_ready;
  logic err;

  int total = 0;
  int bad   = 0;

  conv_layer_sequencer #(
    .W         (W),
    .D         (D),
    .NUM_LAYERS(NL),
    .TIMEOUT   (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_v           (in_v),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .conv_rst       (conv_rst),
    .conv_apply_relu(conv_apply_relu),
    .conv_a0        (conv_a0),
    .conv_a1        (conv_a1),
    .conv_a2        (conv_a2),
    .conv_a3        (conv_a3),
    .conv_out_v     (conv_out_v),
    .conv_out       (conv_out),
    .out_v          (out_v),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Conv1d stand-in: on its start pulse it grabs the newest tap (xor a per-layer mask)
  // and raises out_v once, lat[l] cycles later; kill_layer never answers.
  int            age [NL];
  int            lat [NL];
  int            kill_layer = -1;
  logic [DW-1:0] mask [NL];
  logic [DW-1:0] res  [NL];

  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (conv_rst[l]) begin
        age[l] <= 1;
        res[l] <= conv_a3 ^ mask[l];
      end else if (age[l] != 0 && age[l] < 1000) begin
        age[l] <= age[l] + 1;
      end
    end
  end

  always_comb begin
    conv_out_v = '0;
    conv_out   = '0;
    for (int l = 0; l < NL; l++) begin
      conv_out_v[l] = (l != kill_layer) && (age[l] == lat[l]);
      conv_out[(NL-1-l)*DW +: DW] = res[l];
    end
  end

  // Reference: per-layer log of every vector written since reset, newest last.
  logic [DW-1:0] hlog [NL][HMAX];
  int            hn   [NL];
  logic          err_exp;
  logic [DW-1:0] last_t [4];

  initial begin
    #400000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input int unsigned e);
    logic [W-1:0] el;
    el = W'(e);
    return {D{el}};
  endfunction

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    in_v      = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    chk("rst_conv_rst", DW'(conv_rst), DW'({NL{1'b1}}));
    chk("rst_in_ready", DW'(in_ready), '0);
    chk("rst_out_v",    DW'(out_v),    '0);
    chk("rst_err",      DW'(err),      '0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_conv_rst", DW'(conv_rst), '0);
    chk("post_rst_in_ready", DW'(in_ready), DW'(1));
    chk("post_rst_err",      DW'(err),      '0);
    for (int l = 0; l < NL; l++) hn[l] = 0;
    err_exp = 1'b0;
  endtask

  // One sample through all layers; abort_layer stops at that layer's first WAIT cycle.
  task automatic run_sample(input logic [DW-1:0] x, input int hold, input int abort_layer);
    logic [DW-1:0] v;
    logic [DW-1:0] e [4];
    int n, d;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("idle_in_ready", DW'(in_ready), DW'(1));
    in_v    = 1'b1;
    in_data = x;
    step();
    in_data = rnd();  // keep in_v high with junk: must be ignored while busy
    v = x;
    for (int l = 0; l < NL; l++) begin
      chk("push_in_ready", DW'(in_ready), '0);
      chk("push_out_v",    DW'(out_v),    '0);
      hlog[l][hn[l]] = v;
      hn[l]++;
      d = 1;
      for (int k = 0; k < l; k++) d = d * 4;
      for (int m = 0; m < 4; m++)
        e[m] = (m * d < hn[l]) ? hlog[l][hn[l] - 1 - m * d] : '0;
      step();
      chk("start_conv_rst", DW'(conv_rst), DW'(1) << l);
      chk("start_a3", conv_a3, e[0]);
      chk("start_a2", conv_a2, e[1]);
      chk("start_a1", conv_a1, e[2]);
      chk("start_a0", conv_a0, e[3]);
      chk("start_relu", DW'(conv_apply_relu), DW'(l < NL - 1));
      if (l == NL - 1) begin
        last_t[0] = conv_a3;
        last_t[1] = conv_a2;
        last_t[2] = conv_a1;
        last_t[3] = conv_a0;
      end
      step();
      chk("wait_conv_rst", DW'(conv_rst), '0);
      if (l == abort_layer) return;
      if (l == kill_layer) begin
        for (int k = 1; k < TO; k++) step();
        chk("timeout_err_before", DW'(err), DW'(err_exp));
        step();
        err_exp = 1'b1;
        chk("timeout_err",  DW'(err),      DW'(1));
        chk("timeout_idle", DW'(in_ready), DW'(1));
        in_v = 1'b0;
        return;
      end
      for (int k = 1; k < lat[l]; k++) step();
      step();
      chk("capture_a3", conv_a3, e[0]);
      chk("capture_a0", conv_a0, e[3]);
      chk("capture_relu", DW'(conv_apply_relu), DW'(l < NL - 1));
      chk("capture_out_v", DW'(out_v), '0);
      v = v ^ mask[l];
      step();
    end
    chk("out_v",        DW'(out_v),    DW'(1));
    chk("out_data",     out_data,      v);
    chk("out_in_ready", DW'(in_ready), '0);
    chk("out_err",      DW'(err),      DW'(err_exp));
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_out_v",    DW'(out_v),    DW'(1));
      chk("hold_out_data", out_data,      v);
      chk("hold_in_ready", DW'(in_ready), '0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_v      = 1'b0;
    chk("done_out_v",    DW'(out_v),    '0);
    chk("done_in_ready", DW'(in_ready), DW'(1));
  endtask

  task automatic set_lat(input int lo, input int hi);
    for (int l = 0; l < NL; l++) lat[l] = $urandom_range(hi, lo);
  endtask

  initial begin
    rst       = 1'b1;
    in_v      = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    err_exp   = 1'b0;
    for (int l = 0; l < NL; l++) begin
      mask[l] = '0;
      lat[l]  = 10;
      hn[l]   = 0;
    end
    step();
    do_reset();

    // Identity layers, 10-cycle latency each: result 40 cycles after accept.
    run_sample(rep(1), 0, -1);

    // Samples 1..60 into fresh history: dilated taps and layer-2 ring wrap.
    do_reset();
    for (int n = 1; n <= 60; n++) begin
      set_lat(1, 4);
      run_sample(rep(n), 0, -1);
      if (n == 20) begin
        chk("l2_s20_a3", last_t[0], rep(20));
        chk("l2_s20_a2", last_t[1], rep(4));
        chk("l2_s20_a1", last_t[2], '0);
        chk("l2_s20_a0", last_t[3], '0);
      end
    end
    chk("l2_s60_a3", last_t[0], rep(60));
    chk("l2_s60_a2", last_t[1], rep(44));
    chk("l2_s60_a1", last_t[2], rep(28));
    chk("l2_s60_a0", last_t[3], rep(12));

    // Layer 1 never answers: timeout, then normal operation with err held.
    set_lat(3, 6);
    kill_layer = 1;
    run_sample(rnd(), 0, -1);
    kill_layer = -1;
    run_sample(rnd(), 0, -1);

    // Back-pressure for 5 cycles in OUTPUT.
    run_sample(rnd(), 5, -1);

    // Reset in layer-1 WAIT; next sample must see empty history.
    set_lat(2, 8);
    run_sample(rnd(), 0, 1);
    do_reset();
    for (int l = 0; l < NL; l++) mask[l] = rnd();
    run_sample(rnd(), 2, -1);

    // Random data, masks, latencies, back-pressure and occasional timeouts.
    for (int i = 0; i < 25; i++) begin
      for (int l = 0; l < NL; l++) mask[l] = rnd();
      set_lat(1, 12);
      kill_layer = ($urandom_range(7, 0) == 0) ? int'($urandom_range(NL - 1, 0)) : -1;
      run_sample(rnd(), $urandom_range(3, 0), -1);
    end
    kill_layer = -1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
